pe_array_ctrl: RTL and testbench

//  Sequencer that sits directly upstream of the Life PE array and drives its shared cmd bus,
//  row/col selects and state_in. It performs three operations:
//   - loads cells via a valid/ready write port
//   - runs N generations of PE_CMD_PROCESS, stopping early when the array goes quiet
//   - reads single cells back via OR-reduced state_out

---
 rtl/pe_ctrl_pkg.sv | 20 ++
 rtl/onehot_dec.sv | 17 +
 rtl/pe_decs.sv | 11 +
 rtl/pe_array_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pe_array_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_ctrl_pkg.sv
// rtl/pe_ctrl_pkg.sv - Sequencer state type and typed aliases of the PE command codes
`include "pe_decs.sv"

package pe_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    PROCESS = 2'd2,
    READ    = 2'd3
  } ctrl_state_t;

  localparam int CMD_BITS      = `PE_CMD_BITS;
  localparam int PE_STATE_BITS = `PE_STATE_BITS;

  localparam logic [CMD_BITS-1:0] CMD_NOP     = `PE_CMD_NOP;
  localparam logic [CMD_BITS-1:0] CMD_WRITE   = `PE_CMD_WRITE;
  localparam logic [CMD_BITS-1:0] CMD_PROCESS = `PE_CMD_PROCESS;

endpackage

// File: rtl/onehot_dec.sv
// rtl/onehot_dec.sv - Binary index to N-bit one-hot; all zeros when the index is out of range
module onehot_dec #(
  parameter int N = 8,
  parameter int W = $clog2(N) + 1
) (
  input  logic [W-1:0] idx,
  output logic [N-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == W'(i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/pe_decs.sv
// rtl/pe_decs.sv - Shared Life PE command codes and state width
`ifndef PE_DECS_SV
`define PE_DECS_SV

`define PE_STATE_BITS  1
`define PE_CMD_BITS    2
`define PE_CMD_NOP     2'd0
`define PE_CMD_WRITE   2'd1
`define PE_CMD_PROCESS 2'd2

`endif

// File: rtl/pe_array_ctrl.sv
// rtl/pe_array_ctrl.sv - Sequencer driving the Life PE array command, select and data buses
module pe_array_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int STATE_BITS = PE_STATE_BITS,
  parameter int GEN_BITS   = 16,
  // One spare index bit so that an out-of-range row/column can actually be presented.
  localparam int ROW_W     = $clog2(ROWS) + 1,
  localparam int COL_W     = $clog2(COLS) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ROW_W-1:0]      wr_row,
  input  logic [COL_W-1:0]      wr_col,
  input  logic [STATE_BITS-1:0] wr_state,
  input  logic                  run,
  input  logic [GEN_BITS-1:0]   gen_req,
  input  logic                  rd_req,
  input  logic [ROW_W-1:0]      rd_row,
  input  logic [COL_W-1:0]      rd_col,
  output logic                  rd_valid,
  output logic [STATE_BITS-1:0] rd_state,
  output logic                  busy,
  output logic                  done,
  output logic                  stable,
  output logic [GEN_BITS-1:0]   gens_done,
  output logic [CMD_BITS-1:0]   cmd,
  output logic [ROWS-1:0]       rsel_i,
  output logic [COLS-1:0]       csel_i,
  output logic [STATE_BITS-1:0] state_in,
  output logic [ROWS-1:0]       rsel_o,
  output logic [COLS-1:0]       csel_o,
  input  logic [STATE_BITS-1:0] array_state,
  input  logic                  array_active
);

  ctrl_state_t state, state_n;

  logic [ROWS-1:0] wr_row_oh, rd_row_oh, rsel_i_n, rsel_o_n;
  logic [COLS-1:0] wr_col_oh, rd_col_oh, csel_i_n, csel_o_n;
  logic            wr_hit, rd_hit;

  logic [CMD_BITS-1:0]   cmd_n;
  logic [STATE_BITS-1:0] state_in_n, rd_state_n;
  logic                  rd_valid_n, done_n, stable_n;
  logic [GEN_BITS-1:0]   gens_done_n, gen_target, gen_target_n, gens_inc;

  onehot_dec #(.N(ROWS), .W(ROW_W)) u_wr_row (.idx(wr_row), .onehot(wr_row_oh));
  onehot_dec #(.N(COLS), .W(COL_W)) u_wr_col (.idx(wr_col), .onehot(wr_col_oh));
  onehot_dec #(.N(ROWS), .W(ROW_W)) u_rd_row (.idx(rd_row), .onehot(rd_row_oh));
  onehot_dec #(.N(COLS), .W(COL_W)) u_rd_col (.idx(rd_col), .onehot(rd_col_oh));

  // A half-valid address selects nothing: both selects stay zero.
  assign wr_hit   = (|wr_row_oh) && (|wr_col_oh);
  assign rd_hit   = (|rd_row_oh) && (|rd_col_oh);
  assign gens_inc = (&gens_done) ? gens_done : gens_done + 1'b1;

  always_comb begin
    state_n      = state;
    cmd_n        = CMD_NOP;
    rsel_i_n     = '0;
    csel_i_n     = '0;
    rsel_o_n     = '0;
    csel_o_n     = '0;
    state_in_n   = state_in;
    rd_state_n   = rd_state;
    rd_valid_n   = 1'b0;
    done_n       = 1'b0;
    stable_n     = stable;
    gens_done_n  = gens_done;
    gen_target_n = gen_target;
    case (state)
      IDLE: begin
        if (run) begin
          gens_done_n  = '0;
          stable_n     = 1'b0;
          gen_target_n = gen_req;
          if (gen_req == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = PROCESS;
            cmd_n   = CMD_PROCESS;
          end
        end else if (wr_valid) begin
          state_n    = WRITE;
          state_in_n = wr_state;
          if (wr_hit) begin
            cmd_n    = CMD_WRITE;
            rsel_i_n = wr_row_oh;
            csel_i_n = wr_col_oh;
          end
        end else if (rd_req) begin
          state_n = READ;
          if (rd_hit) begin
            rsel_o_n = rd_row_oh;
            csel_o_n = rd_col_oh;
          end
        end
      end
      WRITE: state_n = IDLE;
      PROCESS: begin
        // array_active describes the generation being processed right now.
        gens_done_n = gens_inc;
        if (!array_active || (gens_inc >= gen_target)) begin
          state_n  = IDLE;
          done_n   = 1'b1;
          stable_n = !array_active;
        end else begin
          cmd_n = CMD_PROCESS;
        end
      end
      READ: begin
        state_n    = IDLE;
        rd_state_n = array_state;
        rd_valid_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cmd        <= CMD_NOP;
      rsel_i     <= '0;
      csel_i     <= '0;
      rsel_o     <= '0;
      csel_o     <= '0;
      state_in   <= '0;
      rd_state   <= '0;
      rd_valid   <= 1'b0;
      done       <= 1'b0;
      stable     <= 1'b0;
      gens_done  <= '0;
      gen_target <= '0;
      wr_ready   <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cmd        <= cmd_n;
      rsel_i     <= rsel_i_n;
      csel_i     <= csel_i_n;
      rsel_o     <= rsel_o_n;
      csel_o     <= csel_o_n;
      state_in   <= state_in_n;
      rd_state   <= rd_state_n;
      rd_valid   <= rd_valid_n;
      done       <= done_n;
      stable     <= stable_n;
      gens_done  <= gens_done_n;
      gen_target <= gen_target_n;
      wr_ready   <= (state_n == IDLE);
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb/tb_pe_array_ctrl.sv - Scoreboard bench for pe_array_ctrl against an 8x8 Life array model
module tb_pe_array_ctrl;
  import pe_ctrl_pkg::*;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int SB   = 1;
  localparam int GB   = 16;
  localparam int RW   = $clog2(ROWS) + 1;
  localparam int CW   = $clog2(COLS) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_valid, wr_ready, run, rd_req, rd_valid, busy, done, stable, array_active;
  logic [RW-1:0] wr_row, rd_row;
  logic [CW-1:0] wr_col, rd_col;
  logic [SB-1:0] wr_state, rd_state, state_in, array_state;
  logic [GB-1:0] gen_req, gens_done;
  logic [CMD_BITS-1:0] cmd;
  logic [ROWS-1:0] rsel_i, rsel_o;
  logic [COLS-1:0] csel_i, csel_o;

  pe_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .STATE_BITS(SB), .GEN_BITS(GB)) dut (
    .clk(clk), .rst(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col), .wr_state(wr_state),
    .run(run), .gen_req(gen_req),
    .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col), .rd_valid(rd_valid), .rd_state(rd_state),
    .busy(busy), .done(done), .stable(stable), .gens_done(gens_done),
    .cmd(cmd), .rsel_i(rsel_i), .csel_i(csel_i), .state_in(state_in),
    .rsel_o(rsel_o), .csel_o(csel_o),
    .array_state(array_state), .array_active(array_active)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // PE array model: Life on a bounded grid, dead cells outside the edges
  logic       clr_grid = 1'b1;
  logic [7:0] grid [8];
  logic [7:0] nxt [8];

  always_comb begin
    int n;
    for (int r = 0; r < ROWS; r++) begin
      nxt[r] = '0;
      for (int c = 0; c < COLS; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && r + dr >= 0 && r + dr < ROWS && c + dc >= 0 && c + dc < COLS)
              if (grid[r+dr][c+dc]) n++;
        nxt[r][c] = (n == 3) || (grid[r][c] && n == 2);
      end
    end
  end

  always_comb begin
    array_active = 1'b0;
    for (int r = 0; r < ROWS; r++) if (nxt[r] != grid[r]) array_active = 1'b1;
    if (cmd != CMD_PROCESS) array_active = 1'b0;
  end

  always_comb begin
    array_state = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (rsel_o[r] && csel_o[c] && grid[r][c]) array_state = 1'b1;
  end

  always @(posedge clk) begin
    if (clr_grid) begin
      for (int r = 0; r < ROWS; r++) grid[r] <= '0;
    end else if (cmd == CMD_WRITE) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (rsel_i[r] && csel_i[c]) grid[r][c] <= state_in[0];
    end else if (cmd == CMD_PROCESS) begin
      for (int r = 0; r < ROWS; r++) grid[r] <= nxt[r];
    end
  end

  // Scoreboard
  typedef struct packed {
    logic [GB-1:0] gens;
    logic          stable;
  } run_exp_t;

  logic     rd_q [$];
  run_exp_t run_q [$];
  logic     rd_exp;
  run_exp_t run_exp;

  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (rd_q.size() == 0) check_val("rd_valid_unexpected", 32'(rd_valid), 0);
      else begin
        rd_exp = rd_q.pop_front();
        check_val("rd_state", 32'(rd_state), 32'(rd_exp));
      end
    end
    if (!rst && done) begin
      if (run_q.size() == 0) check_val("done_unexpected", 32'(done), 0);
      else begin
        run_exp = run_q.pop_front();
        check_val("gens_done", 32'(gens_done), 32'(run_exp.gens));
        check_val("stable", 32'(stable), 32'(run_exp.stable));
      end
    end
  end

  function automatic logic [7:0] oh8(input int idx, input int other, input int lim_i, input int lim_o);
    logic [7:0] v;
    v = '0;
    if (idx < lim_i && other < lim_o) v[idx] = 1'b1;
    return v;
  endfunction

  task automatic cell_write(input int r, input int c, input logic s);
    logic [7:0] er, ec;
    er = oh8(r, c, ROWS, COLS);
    ec = oh8(c, r, COLS, ROWS);
    check_val("wr_ready_idle", 32'(wr_ready), 1);
    wr_valid = 1'b1; wr_row = RW'(r); wr_col = CW'(c); wr_state = s;
    @(negedge clk);
    wr_valid = 1'b0;
    check_val("wr_cmd", 32'(cmd), (er != 0) ? 32'(CMD_WRITE) : 32'(CMD_NOP));
    check_val("wr_rsel_i", 32'(rsel_i), 32'(er));
    check_val("wr_csel_i", 32'(csel_i), 32'(ec));
    check_val("wr_ready_blocked", 32'(wr_ready), 0);
    @(negedge clk);
    check_val("wr_end_cmd", 32'(cmd), 32'(CMD_NOP));
    check_val("wr_end_rsel_i", 32'(rsel_i), 0);
  endtask

  task automatic cell_read(input int r, input int c, input logic expv);
    rd_q.push_back(expv);
    rd_req = 1'b1; rd_row = RW'(r); rd_col = CW'(c);
    @(negedge clk);
    rd_req = 1'b0;
    check_val("rd_busy", 32'(busy), 1);
    check_val("rd_rsel_o", 32'(rsel_o), 32'(oh8(r, c, ROWS, COLS)));
    check_val("rd_csel_o", 32'(csel_o), 32'(oh8(c, r, COLS, ROWS)));
    check_val("rd_early", 32'(rd_valid), 0);
    @(negedge clk);
    check_val("rd_latency", 32'(rd_valid), 1);
  endtask

  task automatic run_gens(input int n, input int exp_gens, input logic exp_stable);
    int  pcnt, lat;
    logic seen;
    run_q.push_back('{gens: GB'(exp_gens), stable: exp_stable});
    run = 1'b1; gen_req = GB'(n);
    @(negedge clk);
    run = 1'b0;
    pcnt = 0; lat = 0; seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin seen = 1'b1; lat = i; break; end
      if (cmd == CMD_PROCESS) pcnt++;
      @(negedge clk);
    end
    check_val("run_done_seen", 32'(seen), 1);
    check_val("process_cycles", 32'(pcnt), 32'(exp_gens));
    check_val("done_latency", 32'(lat), 32'(exp_gens));
    check_val("done_busy", 32'(busy), 0);
    @(negedge clk);
    check_val("done_pulse", 32'(done), 0);
  endtask

  initial begin
    logic bad;
    wr_valid = 0; wr_row = '0; wr_col = '0; wr_state = '0;
    run = 0; gen_req = '0; rd_req = 0; rd_row = '0; rd_col = '0;
    repeat (2) @(negedge clk);
    check_val("rst_cmd", 32'(cmd), 32'(CMD_NOP));
    check_val("rst_wr_ready", 32'(wr_ready), 1);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_rd_valid", 32'(rd_valid), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_stable", 32'(stable), 0);
    check_val("rst_gens_done", 32'(gens_done), 0);
    check_val("rst_selects", 32'({rsel_i, csel_i, rsel_o, csel_o}), 0);
    check_val("rst_rd_state", 32'({rd_state, state_in}), 0);
    rst = 1'b0; clr_grid = 1'b0;
    @(negedge clk);

    cell_write(2, 3, 1'b1);
    cell_read(2, 3, 1'b1);
    cell_read(2, 4, 1'b0);
    cell_write(2, 3, 1'b0);

    cell_write(3, 2, 1'b1);
    cell_write(3, 3, 1'b1);
    cell_write(3, 4, 1'b1);
    run_gens(4, 4, 1'b0);
    cell_read(3, 2, 1'b1);
    cell_read(3, 3, 1'b1);
    cell_read(3, 4, 1'b1);
    cell_read(2, 3, 1'b0);
    cell_read(4, 3, 1'b0);

    run = 1'b1; gen_req = GB'(100);
    @(negedge clk);
    run = 1'b0;
    repeat (4) @(negedge clk);
    check_val("mid_run_cmd", 32'(cmd), 32'(CMD_PROCESS));
    rst = 1'b1;
    @(negedge clk);
    check_val("abort_cmd", 32'(cmd), 32'(CMD_NOP));
    check_val("abort_busy", 32'(busy), 0);
    check_val("abort_selects", 32'({rsel_i, csel_i, rsel_o, csel_o}), 0);
    check_val("abort_wr_ready", 32'(wr_ready), 1);
    check_val("abort_gens_done", 32'(gens_done), 0);
    rst = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) bad = 1'b1;
    end
    check_val("abort_no_done", 32'(bad), 0);

    cell_write(2, 3, 1'b0);
    cell_write(3, 2, 1'b0);
    cell_write(3, 3, 1'b0);
    cell_write(3, 4, 1'b0);
    cell_write(4, 3, 1'b0);
    cell_write(5, 5, 1'b1);
    cell_write(5, 6, 1'b1);
    cell_write(6, 5, 1'b1);
    cell_write(6, 6, 1'b1);
    run_gens(10, 1, 1'b1);

    run_q.push_back('{gens: GB'(1), stable: 1'b1});
    run = 1'b1; gen_req = GB'(3);
    wr_valid = 1'b1; wr_row = RW'(0); wr_col = CW'(0); wr_state = 1'b1;
    rd_req = 1'b1; rd_row = RW'(5); rd_col = CW'(5);
    @(negedge clk);
    run = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
    check_val("arb_cmd", 32'(cmd), 32'(CMD_PROCESS));
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (cmd == CMD_WRITE || rsel_i != 0 || rsel_o != 0 || rd_valid) bad = 1'b1;
      @(negedge clk);
    end
    check_val("arb_no_write_read", 32'(bad), 0);
    cell_read(0, 0, 1'b0);

    run_gens(0, 0, 1'b0);

    cell_write(9, 1, 1'b1);
    cell_read(1, 1, 1'b0);
    cell_read(9, 1, 1'b0);
    cell_read(5, 5, 1'b1);

    repeat (3) @(negedge clk);
    check_val("rd_q_drained", 32'(rd_q.size()), 0);
    check_val("run_q_drained", 32'(run_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
